// File: rtl/joystick_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : joystick_serializer_pkg
// Brief    : Frame layout, state encoding and frame builder for the serializer
// Revision : 1.0 - initial release
// ============================================================================
package joystick_serializer_pkg;

    localparam int FRAME_LEN = 16;
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    localparam int MARK0   = 0;
    localparam int MARK1   = 1;
    localparam int J2_BASE = 2;
    localparam int PAD0    = 8;
    localparam int PAD1    = 9;
    localparam int J1_BASE = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Wire order of one stick is B5, B4, B0, B1, B2, B3; element 0 goes out first.
    function automatic logic [5:0] button_group(input logic [5:0] joy);
        return ~{joy[3], joy[2], joy[1], joy[0], joy[4], joy[5]};
    endfunction

    // Frame index i lives at bit FRAME_LEN-1-i so the MSB is always on the wire.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [5:0] j1,
                                                         input logic [5:0] j2);
        logic [FRAME_LEN-1:0] f;
        logic [5:0]           g1;
        logic [5:0]           g2;
        f  = '1;
        g1 = button_group(j1);
        g2 = button_group(j2);
        f[FRAME_LEN-1-MARK0] = 1'b1;
        f[FRAME_LEN-1-MARK1] = 1'b1;
        f[FRAME_LEN-1-PAD0]  = 1'b1;
        f[FRAME_LEN-1-PAD1]  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            f[FRAME_LEN-1-(J2_BASE+k)] = g2[k];
            f[FRAME_LEN-1-(J1_BASE+k)] = g1[k];
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/joystick_serializer_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Brief    : SYNC-stage synchroniser with history flop for edge/level detect
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic prev,
    output logic rise,
    output logic fall
);

    logic [SYNC-1:0] r_sync;
    logic            r_hist;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], din};
            r_hist <= r_sync[SYNC-1];
        end
    end

    assign level = r_sync[SYNC-1];
    assign prev  = r_hist;
    assign rise  = r_sync[SYNC-1] & ~r_hist;
    assign fall  = ~r_sync[SYNC-1] & r_hist;

endmodule
`default_nettype wire

// File: rtl/joystick_serializer.sv
`default_nettype none
// ============================================================================
// Module   : joystick_serializer
// Brief    : 74HC165-style responder presenting two 6-button sticks on joyD
// Revision : 1.0 - initial release
// ============================================================================
module joystick_serializer
    import joystick_serializer_pkg::*;
#(
    parameter int SYNC = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       joyCk,
    input  logic       joyLd,
    output logic       joyD,
    input  logic [7:0] joy1,
    input  logic [7:0] joy2,
    output logic       loaded,
    output logic       done
);

    logic w_ck_level, w_ck_prev, w_ck_rise, w_ck_fall;
    logic w_ld_level, w_ld_prev, w_ld_rise, w_ld_fall;

    sync_edge #(.SYNC(SYNC)) u_ck_sync (
        .clock (clock),
        .reset (reset),
        .din   (joyCk),
        .level (w_ck_level),
        .prev  (w_ck_prev),
        .rise  (w_ck_rise),
        .fall  (w_ck_fall)
    );

    sync_edge #(.SYNC(SYNC)) u_ld_sync (
        .clock (clock),
        .reset (reset),
        .din   (joyLd),
        .level (w_ld_level),
        .prev  (w_ld_prev),
        .rise  (w_ld_rise),
        .fall  (w_ld_fall)
    );

    state_t               r_state, w_state_next;
    logic [FRAME_LEN-1:0] r_shift, w_shift_next;
    logic [CNT_W-1:0]     r_count, w_count_next;
    logic                 r_loaded, w_loaded_next;
    logic                 r_done, w_done_next;
    logic                 w_shift_en;

    // A clock edge coinciding with the load release must not eat index 0.
    assign w_shift_en = w_ck_rise & w_ld_prev;

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_count_next  = r_count;
        w_loaded_next = 1'b0;
        w_done_next   = 1'b0;
        if (!w_ld_level) begin
            w_state_next = LOAD;
            w_shift_next = build_frame(joy1[5:0], joy2[5:0]);
            w_count_next = '0;
        end else begin
            case (r_state)
                IDLE: ;
                LOAD: begin
                    w_state_next  = SHIFT;
                    w_loaded_next = 1'b1;
                    w_count_next  = '0;
                end
                SHIFT: begin
                    if (w_shift_en) begin
                        w_shift_next = {r_shift[FRAME_LEN-2:0], 1'b1};
                        w_count_next = r_count + 1'b1;
                        if (r_count == LAST_IDX - 1'b1) begin
                            w_done_next  = 1'b1;
                            w_state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (w_shift_en) begin
                        w_shift_next = {r_shift[FRAME_LEN-2:0], 1'b1};
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_shift  <= '1;
            r_count  <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_count  <= w_count_next;
            r_loaded <= w_loaded_next;
            r_done   <= w_done_next;
        end
    end

    assign joyD   = r_shift[FRAME_LEN-1];
    assign loaded = r_loaded;
    assign done   = r_done;

    logic w_unused;
    assign w_unused = &{1'b0, w_ck_level, w_ck_prev, w_ck_fall, w_ld_rise,
                        w_ld_fall, joy1[7:6], joy2[7:6]};

endmodule
`default_nettype wire

// File: tb/tb_joystick_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_joystick_serializer
// Brief    : Reader model plus frame reference model for joystick_serializer
// Revision : 1.0 - initial release
// ============================================================================
module tb_joystick_serializer;

    localparam int H    = 50;
    localparam int SYNC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       joyCk = 1'b0;
    logic       joyLd = 1'b1;
    logic       joyD;
    logic [7:0] joy1  = 8'h00;
    logic [7:0] joy2  = 8'h00;
    logic       loaded;
    logic       done;

    int n_checks = 0;
    int n_fails  = 0;
    int n_loaded = 0;
    int n_done   = 0;

    joystick_serializer #(.SYNC(SYNC)) dut (
        .clock  (clock),
        .reset  (reset),
        .joyCk  (joyCk),
        .joyLd  (joyLd),
        .joyD   (joyD),
        .joy1   (joy1),
        .joy2   (joy2),
        .loaded (loaded),
        .done   (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (loaded) n_loaded++;
        if (done)   n_done++;
    end

    // Expected wire level for frame index i (indices past the frame read as fill).
    function automatic logic exp_bit(input int i, input logic [7:0] j1, input logic [7:0] j2);
        int ord [6] = '{5, 4, 0, 1, 2, 3};
        if (i >= 2 && i <= 7)   return ~j2[ord[i-2]];
        if (i >= 10 && i <= 15) return ~j1[ord[i-10]];
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // mode: 0 plain, 1 reload at at_k, 2 change joy1 at at_k, 3 reset at at_k
    task automatic frame(input logic [7:0] j1, input logic [7:0] j2, input int nclk,
                         input int mode, input int at_k, input logic [7:0] chg);
        logic [15:0] got;
        logic [7:0]  j1o, j2o;
        int          ord [6] = '{5, 4, 0, 1, 2, 3};
        int          d0, l0;
        got  = '1;
        d0   = n_done;
        l0   = n_loaded;
        joy1 = j1;
        joy2 = j2;
        joyCk = 1'b0;
        joyLd = 1'b0;
        wait_cyc(H);
        joyLd = 1'b1;
        joyCk = 1'b1;
        for (int k = 0; k < nclk; k++) begin
            wait_cyc(H);
            chk($sformatf("bit%0d", k), 16'(joyD), 16'(exp_bit(k, j1, j2)));
            if (k < 16) got[k] = joyD;
            if (k == 14) chk("done_early", 16'(n_done), 16'(d0));
            if (k == 15) chk("done_at15", 16'(n_done), 16'(d0 + 1));
            if (mode == 2 && k == at_k) joy1 = chg;
            if (mode == 1 && k == at_k) begin
                joyLd = 1'b0;
                joyCk = 1'b0;
                wait_cyc(SYNC + 3);
                chk("reload_idx0", 16'(joyD), 16'(exp_bit(0, j1, j2)));
                return;
            end
            if (mode == 3 && k == at_k) begin
                #1 reset = 1'b0;
                #1;
                chk("async_rst_joyD", 16'(joyD), 16'h1);
                chk("async_rst_pulses", {14'h0, loaded, done}, 16'h0);
                @(negedge clock);
                joyCk = 1'b0;
                joyLd = 1'b1;
                wait_cyc(5);
                reset = 1'b1;
                for (int t = 0; t < 3; t++) begin
                    wait_cyc(10);
                    joyCk = ~joyCk;
                end
                wait_cyc(10);
                chk("idle_after_rst", 16'(joyD), 16'h1);
                chk("no_done_after_rst", 16'(n_done), 16'(d0));
                return;
            end
            joyCk = 1'b0;
            wait_cyc(H);
            if (k < nclk - 1) joyCk = 1'b1;
        end
        chk("done_count", 16'(n_done), 16'(d0 + 1));
        chk("loaded_count", 16'(n_loaded), 16'(l0 + 1));
        j1o = 8'h00;
        j2o = 8'h00;
        for (int m = 0; m < 6; m++) begin
            j2o[ord[m]] = ~got[2 + m];
            j1o[ord[m]] = ~got[10 + m];
        end
        chk("loop_joy1", 16'(j1o), 16'({2'b00, j1[5:0]}));
        chk("loop_joy2", 16'(j2o), 16'({2'b00, j2[5:0]}));
    endtask

    initial begin
        wait_cyc(3);
        chk("rst_joyD", 16'(joyD), 16'h1);
        chk("rst_pulses", {14'h0, loaded, done}, 16'h0);
        reset = 1'b1;
        for (int t = 0; t < 6; t++) begin
            wait_cyc(10);
            joyCk = ~joyCk;
        end
        wait_cyc(10);
        chk("idle_joyD", 16'(joyD), 16'h1);
        chk("idle_loaded", 16'(n_loaded), 16'h0);
        chk("idle_done", 16'(n_done), 16'h0);

        frame(8'h01, 8'h00, 16, 0, -1, 8'h00);
        frame(8'h10, 8'h20, 16, 0, -1, 8'h00);
        frame(8'hC0, 8'h00, 16, 0, -1, 8'h00);
        frame(8'($urandom), 8'($urandom), 20, 0, -1, 8'h00);
        frame(8'h3F, 8'h15, 16, 1, 6, 8'h00);
        frame(8'h3F, 8'h15, 16, 0, -1, 8'h00);
        frame(8'h0A, 8'h2C, 16, 2, 5, 8'h33);
        frame(8'h33, 8'h2C, 16, 0, -1, 8'h00);
        frame(8'($urandom), 8'($urandom), 16, 3, 9, 8'h00);
        for (int r = 0; r < 3; r++) begin
            frame(8'($urandom), 8'($urandom), 16, 0, -1, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
